// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the RV32I pipeline hazard controller:
//   - hz_state_e : memory-wait FSM state encoding (RUN=0, WAIT=1, ERR=2)
//   - HZ_REG_AW / HZ_MEM_TIMEOUT / HZ_CNT_W : parameter defaults
//   - load_use_hit() : register-index comparison used by load-use detection
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN  = 2'd0,
        HZ_WAIT = 2'd1,
        HZ_ERR  = 2'd2
    } hz_state_e;

    localparam int HZ_REG_AW      = 5;
    localparam int HZ_MEM_TIMEOUT = 16;
    localparam int HZ_CNT_W       = 32;

    // True when the EX destination register is a real (non-x0) register that
    // matches either source operand of the instruction in ID.
    function automatic logic load_use_hit(
        input logic [HZ_REG_AW-1:0] rd,
        input logic [HZ_REG_AW-1:0] rs1,
        input logic [HZ_REG_AW-1:0] rs2
    );
        return (rd != {HZ_REG_AW{1'b0}}) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// ---------------------------------------------------------------------------
// hazard_mem_wait_fsm
// Tracks outstanding data-memory accesses. Freezes the pipe while a request
// in MEM is unacknowledged, counts wait cycles and enters a sticky error
// state once MEM_TIMEOUT freeze cycles have elapsed without an ack.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_memReqM, i_memAckM  memory request valid / acknowledge
//   o_freeze              combinational: hold the whole pipe this cycle
//   o_memErr              sticky timeout flag (registered)
//   o_state               current FSM state (registered)
// ---------------------------------------------------------------------------
module hazard_mem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = HZ_MEM_TIMEOUT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_memReqM,
    input  logic       i_memAckM,
    output logic       o_freeze,
    output logic       o_memErr,
    output logic [1:0] o_state
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic              mem_hold_s;

    // Next-state, wait-counter and freeze decode.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        o_freeze   = 1'b0;
        mem_hold_s = i_memReqM & ~i_memAckM;
        case (state_q)
            HZ_RUN: begin
                if (mem_hold_s) begin
                    // The first missed cycle is already a freeze cycle and counts as 1.
                    state_d  = HZ_WAIT;
                    wcnt_d   = WCNT_ONE;
                    o_freeze = 1'b1;
                end else begin
                    wcnt_d = {WCNT_W{1'b0}};
                end
            end
            HZ_WAIT: begin
                if (i_memAckM) begin
                    // Ack releases the pipe in the same cycle.
                    state_d = HZ_RUN;
                    wcnt_d  = {WCNT_W{1'b0}};
                end else if (wcnt_q == WCNT_LAST) begin
                    o_freeze = 1'b1;
                    state_d  = HZ_ERR;
                    err_d    = 1'b1;
                end else begin
                    o_freeze = 1'b1;
                    wcnt_d   = wcnt_q + WCNT_ONE;
                end
            end
            HZ_ERR: begin
                // Only reset leaves ERR; late acks are ignored.
                o_freeze = 1'b1;
                err_d    = 1'b1;
            end
            default: begin
                // Illegal encoding: fail safe into the frozen error state.
                o_freeze = 1'b1;
                state_d  = HZ_ERR;
                err_d    = 1'b1;
            end
        endcase
    end

    // State, wait counter and sticky error registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= HZ_RUN;
            wcnt_q  <= {WCNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign o_memErr = err_q;
    assign o_state  = state_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush controller for the 5-stage RV32I pipeline. Handles load-use
// hazards, taken branches/jumps and memory-wait freezes, and counts stalled
// decode cycles.
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   i_rs1D, i_rs2D                     source indices of the ID instruction
//   i_rdE, i_loadE, i_regWriteE        EX destination / load / write-enable
//   i_pcSrcE                           taken branch or jump in EX
//   i_memReqM, i_memAckM               data-memory request / acknowledge
//   o_stallF/D/E/M, o_flushD/E/W       pipeline register controls (comb.)
//   o_memErr                           sticky memory timeout
//   o_state                            memory-wait FSM state
//   o_stallCnt                         count of cycles with o_stallD=1 (wraps)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = HZ_REG_AW,
    parameter int MEM_TIMEOUT = HZ_MEM_TIMEOUT,
    parameter int CNT_W       = HZ_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_rs1D,
    input  logic [REG_AW-1:0] i_rs2D,
    input  logic [REG_AW-1:0] i_rdE,
    input  logic              i_loadE,
    input  logic              i_regWriteE,
    input  logic              i_pcSrcE,
    input  logic              i_memReqM,
    input  logic              i_memAckM,
    output logic              o_stallF,
    output logic              o_stallD,
    output logic              o_flushD,
    output logic              o_stallE,
    output logic              o_flushE,
    output logic              o_stallM,
    output logic              o_flushW,
    output logic              o_memErr,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_stallCnt
);

    logic             freeze_s;
    logic             lw_stall_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hazard_mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_memReqM (i_memReqM),
        .i_memAckM (i_memAckM),
        .o_freeze  (freeze_s),
        .o_memErr  (o_memErr),
        .o_state   (o_state)
    );

    // Load-use detection: the ID instruction needs a value still being loaded in EX.
    always_comb begin
        lw_stall_s = 1'b0;
        if (i_loadE && i_regWriteE && (i_rdE != {REG_AW{1'b0}})
            && ((i_rdE == i_rs1D) || (i_rdE == i_rs2D))) begin
            lw_stall_s = 1'b1;
        end else begin
            lw_stall_s = 1'b0;
        end
    end

    // Stall/flush decode; reset forces bubbles, freeze overrides hazards and branches.
    always_comb begin
        o_stallF = 1'b0;
        o_stallD = 1'b0;
        o_flushD = 1'b0;
        o_stallE = 1'b0;
        o_flushE = 1'b0;
        o_stallM = 1'b0;
        o_flushW = 1'b0;
        if (i_rst) begin
            o_flushD = 1'b1;
            o_flushE = 1'b1;
            o_flushW = 1'b1;
        end else if (freeze_s) begin
            // Branch stays pending in EX and is serviced on the first unfrozen cycle.
            o_stallF = 1'b1;
            o_stallD = 1'b1;
            o_stallE = 1'b1;
            o_stallM = 1'b1;
            o_flushW = 1'b1;
        end else begin
            o_stallF = lw_stall_s;
            o_stallD = lw_stall_s;
            o_flushD = i_pcSrcE;
            o_flushE = lw_stall_s | i_pcSrcE;
        end
    end

    // Stall performance counter next value; wraps naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stallD) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall performance counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stallCnt = stall_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline. It generates stall (enable) and flush (clear) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and taken branches and jumps, and freezes the whole pipe while the data memory has not acknowledged a request. A timeout turns a hung memory access into a sticky error. A stall-cycle performance counter is included.

Parameters:
REG_AW, 5, register index width
MEM_TIMEOUT, 16, max wait cycles for i_memAckM before error (≥2)
CNT_W, 32, stall performance counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_rs1D  in  REG_AW  rs1 index of the instruction in ID
i_rs2D  in  REG_AW  rs2 index of the instruction in ID
i_rdE  in  REG_AW  rd index of the instruction in EX
i_loadE  in  1  instruction in EX is a load
i_regWriteE  in  1  instruction in EX writes the register file
i_pcSrcE  in  1  taken branch or jump resolved in EX
i_memReqM  in  1  load/store valid in MEM
i_memAckM  in  1  data memory acknowledge (same cycle = zero wait)
o_stallF  out  1  hold PC
o_stallD  out  1  hold IF/ID (decode reg enable = ~o_stallD)
o_flushD  out  1  clear IF/ID
o_stallE  out  1  hold ID/EX
o_flushE  out  1  clear ID/EX
o_stallM  out  1  hold EX/MEM
o_flushW  out  1  clear MEM/WB (bubble)
o_memErr  out  1  sticky memory timeout
o_state  out  2  FSM state, for debug
o_stallCnt  out  CNT_W  cycles with o_stallD=1, wraps

Behaviour:
- Reset (async, i_rst=1): state RUN, wait counter 0, o_memErr 0, o_stallCnt 0. While i_rst=1, all stall outputs are 0 and o_flushD/o_flushE/o_flushW are 1.
- The stall and flush outputs are combinational from state and inputs, taking effect in the same cycle. Only the state, wait counter, error flag and perf counter are registered.
- lwStall = i_loadE & i_regWriteE & (i_rdE!=0) & (i_rdE==i_rs1D | i_rdE==i_rs2D).
- memHold = i_memReqM & ~i_memAckM.
- freeze = (state==WAIT & ~i_memAckM) | (state==RUN & memHold) | state==ERR.
- Encoding: RUN=0, WAIT=1, ERR=2.
- RUN, freeze=0:
  - o_stallF = o_stallD = lwStall.
  - o_flushD = i_pcSrcE.
  - o_flushE = lwStall | i_pcSrcE.
  - o_stallE = o_stallM = o_flushW = 0.
- Freeze (any state): o_stallF = o_stallD = o_stallE = o_stallM = 1, o_flushW = 1, o_flushD = o_flushE = 0. Freeze overrides load-use and branch handling. A branch held in EX keeps i_pcSrcE high and is serviced on the first unfrozen cycle.
- Transitions:
  - RUN→WAIT when memHold; the wait counter loads 1.
  - WAIT→RUN on i_memAckM; the counter clears, and the pipe is released in that same cycle (outputs follow the RUN equations).
  - WAIT, no ack: the counter increments. WAIT→ERR when the counter == MEM_TIMEOUT-1 and there is no ack, so a total of MEM_TIMEOUT freeze cycles are counted.
  - ERR: o_memErr=1, freeze held; leaves ERR only on reset. A late ack in ERR is ignored.
- Zero-wait access (req & ack in the same cycle): no freeze, no state change.
- Back-to-back misses: WAIT→RUN on ack, then RUN→WAIT again on the next memHold; the counter restarts from 1.
- o_stallCnt increments every cycle o_stallD=1, including freeze cycles, and wraps modulo 2^CNT_W.
- Reset mid-WAIT: returns to RUN immediately and the counter clears.
- Wait counter width: $clog2(MEM_TIMEOUT+1).

Decomposition:
- Shared include (riscv_configs): FSM state encodings HZ_RUN/HZ_WAIT/HZ_ERR, REG_AW default, MEM_TIMEOUT default.
- One natural sub-module: hazard_mem_wait_fsm, holding the state, wait counter, error flag and freeze output. The top level adds the load-use/branch logic and the perf counter.

Test Plan:
- Load-use: i_loadE=1, i_regWriteE=1, i_rdE=5, i_rs1D=5 → o_stallF=o_stallD=o_flushE=1, o_flushD=0 for one cycle; with i_rdE=0 → no stall.
- Branch: i_pcSrcE=1 with no load hazard → o_flushD=o_flushE=1, no stalls; load-use and branch together → stallF/D=1, flushD/E=1.
- Memory wait: i_memReqM=1, ack after 3 cycles → freeze outputs =1 for 3 cycles, o_state=1 from the 2nd cycle, release in the ack cycle; o_stallCnt advances by 3.
- Freeze with branch: i_pcSrcE=1 during a memory wait → o_flushD=o_flushE=0 while frozen, then =1 in the ack cycle.
- Timeout: i_memReqM=1 with no ack, MEM_TIMEOUT=16 → o_memErr=1 and o_state=2 after 16 freeze cycles; a late ack changes nothing; i_rst → o_memErr=0, o_state=0.
- Async reset mid-WAIT: assert i_rst between clock edges → outputs take reset values immediately, o_stallCnt=0; zero-wait req+ack afterwards → no freeze.
